mixcolumns_seq: RTL and testbench

Iterative AES MixColumns/InvMixColumns engine that sequences GF(2^8) xtime multipliers over a 128-bit state, COLS columns per cycle. It sits between ShiftRows and AddRoundKey in the round datapath. It takes a state through a valid/ready handshake, runs a column-counter FSM, and returns the mixed state through a held valid/ready output.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/mixcolumn_col.sv | 51 +++++
 rtl/mixcolumns_seq.sv | 138 +++++++++++++
 tb/tb_mixcolumns_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES MixColumns datapath.
//   byte_t / word_t / state_t : one byte, one column, the full 128-bit state
//   AES_POLY                  : low byte of x^8+x^4+x^3+x+1
//   mc_state_t                : engine FSM states
//   xtime()                   : multiply one byte by x in GF(2^8)
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  localparam byte_t AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mc_state_t;

  // Multiplying by x is a left shift. When the top bit falls off, the
  // result is reduced by XORing in the polynomial. This is a carry-less
  // operation, so no integer addition is involved.
  function automatic byte_t xtime(input byte_t b, input byte_t poly);
    return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/mixcolumn_col.sv
// ---------------------------------------------------------------------------
// mixcolumn_col
// Combinational single-column MixColumns / InvMixColumns mixer.
// Ports:
//   inverse_i : 0 = forward matrix {2,3,1,1}, 1 = inverse matrix {14,11,13,9}
//   col_i     : input column, row r byte at col_i[31-8r -: 8]
//   col_o     : mixed column, same byte layout
// ---------------------------------------------------------------------------
module mixcolumn_col
  import aes_pkg::*;
#(
  parameter byte_t POLY = AES_POLY
) (
  input  logic        inverse_i,
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  byte_t a  [4];
  byte_t m1 [4];
  byte_t m2 [4];
  byte_t m3 [4];
  byte_t b  [4];

  // Every coefficient in both matrices can be built from the x, x^2 and x^3
  // powers of a byte plus the byte itself:
  //   2 = x         3 = x ^ 1
  //   9 = x^3 ^ 1   11 = x^3 ^ x ^ 1
  //   13 = x^3 ^ x^2 ^ 1   14 = x^3 ^ x^2 ^ x
  // Each power is computed once per byte, and the results are shared by
  // all four output rows.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r]  = col_i[31-8*r -: 8];
    assign m1[r] = xtime(a[r], POLY);
    assign m2[r] = xtime(m1[r], POLY);
    assign m3[r] = xtime(m2[r], POLY);

    assign b[r] = inverse_i
      ? ((m3[r]       ^ m2[r]       ^ m1[r])
       ^ (m3[(r+1)%4] ^ m1[(r+1)%4] ^ a[(r+1)%4])
       ^ (m3[(r+2)%4] ^ m2[(r+2)%4] ^ a[(r+2)%4])
       ^ (m3[(r+3)%4] ^ a[(r+3)%4]))
      : (m1[r]
       ^ (m1[(r+1)%4] ^ a[(r+1)%4])
       ^ a[(r+2)%4]
       ^ a[(r+3)%4]);

    assign col_o[31-8*r -: 8] = b[r];
  end

endmodule

// File: rtl/mixcolumns_seq.sv
// ---------------------------------------------------------------------------
// mixcolumns_seq
// Iterative AES MixColumns / InvMixColumns engine. A 128-bit state is
// accepted, mixed COLS columns per cycle, and then held until it is consumed.
// Ports:
//   clk, reset          : clock; asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready is high only in IDLE)
//   din, inverse        : state and direction, sampled only on accept
//   out_valid/out_ready : output handshake; dout is held while out_valid=1
//   dout                : mixed state (reads as zero unless out_valid=1)
//   busy                : high while a state is being processed or is held
// COLS must be 1, 2 or 4. Processing takes 4/COLS cycles.
// ---------------------------------------------------------------------------
module mixcolumns_seq
  import aes_pkg::*;
#(
  parameter int    COLS = 1,
  parameter byte_t POLY = AES_POLY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  input  logic         inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);

  mc_state_t  state_q, state_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  state_t     work_q, work_d;
  logic       inv_q, inv_d;

  word_t      colsIn  [4];
  word_t      colsOut [4];
  word_t      grpIn   [COLS];
  word_t      grpOut  [COLS];
  state_t     workMixed;
  logic [2:0] cntSum;

  // Split the work register into columns. Column 0 is the most significant word.
  for (genvar c = 0; c < 4; c++) begin : g_unpack
    assign colsIn[c] = work_q[127-32*c -: 32];
  end

  // One mixer per lane. Lane k works on column col_cnt+k. col_cnt only
  // advances in steps of COLS, so a group never wraps past column 3.
  for (genvar k = 0; k < COLS; k++) begin : g_lane
    assign grpIn[k] = colsIn[col_cnt_q + 2'(k)];

    mixcolumn_col #(
      .POLY(POLY)
    ) u_col (
      .inverse_i(inv_q),
      .col_i    (grpIn[k]),
      .col_o    (grpOut[k])
    );
  end

  // A column is replaced when it belongs to the group that starts at col_cnt.
  // Group boundaries are multiples of COLS, so one equality test against
  // the group's first column is enough. The lane that serves column c is
  // c % COLS.
  for (genvar c = 0; c < 4; c++) begin : g_merge
    assign colsOut[c] = (col_cnt_q == 2'((c / COLS) * COLS))
                        ? grpOut[c % COLS] : colsIn[c];
    assign workMixed[127-32*c -: 32] = colsOut[c];
  end

  assign cntSum = {1'b0, col_cnt_q} + 3'(COLS);

  // Next-state logic. The state is latched on accept and then mixed in
  // place one group per cycle. The FSM moves to DONE once the last group
  // has been written back, and it leaves DONE only on an output handshake.
  // in_ready is low in DONE, so a new state cannot be accepted in the same
  // cycle that a result is consumed.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    inv_d     = inv_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d    = din;
          inv_d     = inverse;
          col_cnt_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        work_d = workMixed;
        if (cntSum == 3'd4) begin
          col_cnt_d = 2'd0;
          state_d   = DONE;
        end else begin
          col_cnt_d = cntSum[1:0];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset aborts any transaction in flight and clears the
  // work register, so a partially mixed state can never leak out later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      work_q    <= '0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
      inv_q     <= inv_d;
    end
  end

  // Outputs are decoded from the state register. dout is gated with
  // out_valid, so a partially mixed state is never visible on the port.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);
  assign dout      = out_valid ? work_q : '0;

endmodule

// File: tb/tb_mixcolumns_seq.sv
// ---------------------------------------------------------------------------
// tb_mixcolumns_seq
// Self-checking bench for mixcolumns_seq. The main instance uses COLS=1.
// Two further instances, with COLS=2 and COLS=4, share din/inverse and are
// used for the latency comparison.
// ---------------------------------------------------------------------------
module tb_mixcolumns_seq;
  import aes_pkg::*;

  logic         clk;
  logic         reset;
  logic [127:0] din;
  logic         inverse;

  logic         inValid, inReady, outValid, outReady, busy;
  logic [127:0] dout;
  logic         inValid2, inReady2, outValid2, outReady2, busy2;
  logic [127:0] dout2;
  logic         inValid4, inReady4, outValid4, outReady4, busy4;
  logic [127:0] dout4;

  int errors = 0;
  int checks = 0;
  state_t sbQueue[$];

  typedef struct {
    state_t din;
    logic   inv;
    state_t expected;
  } vec_t;

  vec_t vecs[6];

  mixcolumns_seq #(.COLS(1)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .din(din), .inverse(inverse), .out_valid(outValid),
    .out_ready(outReady), .dout(dout), .busy(busy)
  );

  mixcolumns_seq #(.COLS(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(inValid2), .in_ready(inReady2),
    .din(din), .inverse(inverse), .out_valid(outValid2),
    .out_ready(outReady2), .dout(dout2), .busy(busy2)
  );

  mixcolumns_seq #(.COLS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(inValid4), .in_ready(inReady4),
    .din(din), .inverse(inverse), .out_valid(outValid4),
    .out_ready(outReady4), .dout(dout4), .busy(busy4)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference multiply: shift-and-add over GF(2^8).
  function automatic byte_t gfMul(input byte_t a, input byte_t b);
    byte_t p = 8'h00;
    byte_t x = a;
    byte_t y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Reference model: circulant matrix product applied to each column.
  function automatic state_t modelMix(input state_t s, input logic inv);
    byte_t  coef[4];
    byte_t  acc;
    state_t res = '0;
    if (inv) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gfMul(coef[j], s[127-32*c-8*((r+j)%4) -: 8]);
        end
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Runs one transaction on the COLS=1 instance, starting and ending just
  // after a rising edge with the engine in IDLE.
  //   earlyReady : hold out_ready high from the accept onwards
  //   disturb    : wiggle din/inverse and hold in_valid high while busy
  //   holdCycles : extra DONE cycles with out_ready low before the consume
  task automatic applyStimulus(input state_t d, input logic inv,
                               input state_t exp, input bit earlyReady,
                               input bit disturb, input int holdCycles);
    int     lat;
    int     holdBad;
    state_t want;
    checkOutput("in_ready before accept", inReady, 1);
    din     = d;
    inverse = inv;
    inValid = 1'b1;
    sbQueue.push_back(exp);
    @(posedge clk); #1;
    inValid = disturb;
    if (earlyReady) outReady = 1'b1;
    checkOutput("busy after accept", {busy, inReady}, 2'b10);
    lat = 0;
    while (!outValid && lat < 20) begin
      if (disturb) begin
        din     = ~din;
        inverse = ~inverse;
      end
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, 4);
    want = (sbQueue.size() > 0) ? sbQueue.pop_front() : '0;
    checkOutput("dout", dout, want);
    if (earlyReady) begin
      @(posedge clk); #1;
      outReady = 1'b0;
    end else begin
      holdBad = 0;
      for (int i = 0; i < holdCycles; i++) begin
        if (disturb) begin
          din     = ~din;
          inverse = ~inverse;
        end
        @(posedge clk); #1;
        if (!outValid || dout !== want || inReady || !busy) holdBad++;
      end
      checkOutput("hold stable", holdBad, 0);
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
    end
    checkOutput("idle after consume", {inReady, outValid, busy}, 3'b100);
    checkOutput("dout after consume", dout, '0);
  endtask

  // Sends the same state to the COLS=2 and COLS=4 instances and measures
  // how many edges pass before each one reports a result.
  task automatic applyWide(input state_t d, input logic inv, input state_t exp);
    int lat2 = 0;
    int lat4 = 0;
    din      = d;
    inverse  = inv;
    inValid2 = 1'b1;
    inValid4 = 1'b1;
    @(posedge clk); #1;
    inValid2 = 1'b0;
    inValid4 = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (outValid2 && lat2 == 0) lat2 = cyc;
      if (outValid4 && lat4 == 0) lat4 = cyc;
    end
    checkOutput("COLS=2 latency", lat2, 2);
    checkOutput("COLS=4 latency", lat4, 1);
    checkOutput("COLS=2 dout", dout2, exp);
    checkOutput("COLS=4 dout", dout4, exp);
    outReady2 = 1'b1;
    outReady4 = 1'b1;
    @(posedge clk); #1;
    outReady2 = 1'b0;
    outReady4 = 1'b0;
    checkOutput("wide idle", {inReady2, inReady4, outValid2, outValid4}, 4'b1100);
  endtask

  initial begin
    int     cyc;
    state_t rnd;
    logic   rinv;

    vecs[0] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
                128'h046681e5e0cb199a48f8d37a2806264c};
    vecs[1] = '{128'h046681e5e0cb199a48f8d37a2806264c, 1'b1,
                128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[2] = '{128'hdb135345c6c6c6c6d4d4d4d5f20a225c, 1'b0,
                128'h8e4da1bcc6c6c6c6d5d5d7d69fdc589d};
    vecs[3] = '{128'h8e4da1bcc6c6c6c6d5d5d7d69fdc589d, 1'b1,
                128'hdb135345c6c6c6c6d4d4d4d5f20a225c};
    vecs[4] = '{128'h2d26314c0101010100000000ffffffff, 1'b0,
                128'h4d7ebdf80101010100000000ffffffff};
    vecs[5] = '{128'h4d7ebdf80101010100000000ffffffff, 1'b1,
                128'h2d26314c0101010100000000ffffffff};

    reset     = 1'b1;
    din       = '0;
    inverse   = 1'b0;
    inValid   = 1'b0;
    outReady  = 1'b0;
    inValid2  = 1'b0;
    outReady2 = 1'b0;
    inValid4  = 1'b0;
    outReady4 = 1'b0;

    @(posedge clk); #1;
    checkOutput("reset in_ready", inReady, 1);
    checkOutput("reset out_valid/busy", {outValid, busy}, 2'b00);
    checkOutput("reset dout", dout, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].din, vecs[i].inv, vecs[i].expected, 1'b0, 1'b0, 0);
    end

    for (int i = 0; i < 4; i++) begin
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      rinv = 1'($urandom_range(0, 1));
      applyStimulus(rnd, rinv, modelMix(rnd, rinv), 1'b0, 1'b0, 0);
    end

    $display("[TB] DONE hold with out_ready low");
    applyStimulus(vecs[0].din, vecs[0].inv, vecs[0].expected, 1'b0, 1'b0, 10);

    $display("[TB] input isolation while busy");
    applyStimulus(vecs[2].din, vecs[2].inv, vecs[2].expected, 1'b0, 1'b1, 3);

    $display("[TB] out_ready held high from accept");
    applyStimulus(vecs[1].din, vecs[1].inv, vecs[1].expected, 1'b1, 1'b0, 0);

    $display("[TB] reset on second BUSY cycle");
    din     = vecs[0].din;
    inverse = vecs[0].inv;
    inValid = 1'b1;
    sbQueue.push_back(vecs[0].expected);
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("mid-reset outputs", {inReady, outValid, busy}, 3'b100);
    checkOutput("mid-reset dout", dout, '0);
    sbQueue.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (outValid || busy) cyc++;
    end
    checkOutput("no result after abort", cyc, 0);
    applyStimulus(vecs[3].din, vecs[3].inv, vecs[3].expected, 1'b0, 1'b0, 0);

    $display("[TB] COLS=2 and COLS=4 builds");
    applyWide(vecs[0].din, vecs[0].inv, vecs[0].expected);
    applyWide(vecs[1].din, vecs[1].inv, vecs[1].expected);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
